// File: rtl/ps2_key_receiver_if.sv
// Key report bus between the PS/2 receiver and the pong game FSM.
//   tasta     [7:0] last valid make code (scan code set 2)
//   done            high while tasta holds a freshly reported make code
//   extended        tasta was preceded by an E0 prefix
//   frame_err       one-clock pulse on a parity, stop or timeout error
// master: driven by the receiver; slave: observed by the consumer.
interface ps2_key_receiver_if;
  logic [7:0] tasta;
  logic       done;
  logic       extended;
  logic       frame_err;

  modport master (output tasta, output done, output extended, output frame_err);
  modport slave  (input  tasta, input  done, input  extended, input  frame_err);
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver feeding the pong game FSM.
// Synchronises and glitch-filters the PS/2 lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), strips break sequences
// (F0 xx), tags extended codes (E0 xx) and stretches `done` so a consumer
// that only samples occasionally still sees each make code.
// Ports:
//   clock     system clock
//   reset     asynchronous, active-low
//   ps2_clk   raw PS/2 clock (asynchronous, receive only)
//   ps2_data  raw PS/2 data  (asynchronous, receive only)
//   key       report bus (tasta, done, extended, frame_err)
module ps2_key_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [19:0] TIMEOUT    = 20'd50000,
  parameter logic [15:0] DONE_HOLD  = 16'd40000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_key_receiver_if.master  key
);

  localparam int unsigned     FW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          fe;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [19:0]   idle_cnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_err_q;

  logic          brk, ext;
  logic          new_code;
  logic [7:0]    tasta_q;
  logic          ext_out;
  logic          done_q;
  logic          pend;
  logic [15:0]   hold_cnt;

  // Two-flop synchronisers; lines idle high so reset to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fe = clk_f_d & ~clk_f;

  // Frame deserialiser. A falling edge on the same cycle as the timeout
  // limit takes priority: the idle count restarts and the frame continues.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      idle_cnt    <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;

      if (state == S_IDLE || fe) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TIMEOUT - 20'd1) begin
        idle_cnt    <= '0;
        state       <= S_IDLE;
        shreg       <= '0;
        frame_err_q <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 20'd1;
      end

      if (fe) begin
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          default: begin
            if (dat_s2 && (^{shreg, par_bit})) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err_q <= 1'b1;
            end
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign new_code = byte_valid && !frame_err_q && !brk &&
                    (rx_byte != 8'hF0) && (rx_byte != 8'hE0);

  // Prefix tracking and make-code capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk     <= 1'b0;
      ext     <= 1'b0;
      tasta_q <= '0;
      ext_out <= 1'b0;
    end else if (frame_err_q) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == 8'hF0) begin
        brk <= 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext <= 1'b1;
      end else if (brk) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else begin
        tasta_q <= rx_byte;
        ext_out <= ext;
        ext     <= 1'b0;
      end
    end
  end

  // Done stretcher. A code arriving while done is high forces one low
  // cycle (pend) so a downstream rising-edge detector sees every report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      pend     <= 1'b0;
      hold_cnt <= '0;
    end else if (new_code) begin
      if (done_q) begin
        done_q <= 1'b0;
        pend   <= 1'b1;
      end else begin
        done_q   <= 1'b1;
        pend     <= 1'b0;
        hold_cnt <= DONE_HOLD;
      end
    end else if (pend) begin
      pend     <= 1'b0;
      done_q   <= 1'b1;
      hold_cnt <= DONE_HOLD;
    end else if (done_q) begin
      if (hold_cnt <= 16'd1) begin
        done_q   <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

  assign key.tasta     = tasta_q;
  assign key.done      = done_q;
  assign key.extended  = ext_out;
  assign key.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;

  logic clock = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_key_receiver_if bus ();
  ps2_key_receiver_if rbus ();

  ps2_key_receiver #(
    .FILTER_LEN (2),
    .TIMEOUT    (20'd200),
    .DONE_HOLD  (16'd50)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (bus)
  );

  // Long hold so back-to-back frames land while done is still high.
  ps2_key_receiver #(
    .FILTER_LEN (2),
    .TIMEOUT    (20'd200),
    .DONE_HOLD  (16'd1000)
  ) u_rep (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (rbus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fall_cyc = 0;

  always @(posedge clock) cyc++;

  // Observers for the main instance.
  int  rise_cnt = 0, hi_run = 0, last_hi_run = 0;
  int  err_cnt = 0, err_run = 0, last_err_run = 0, err_cyc = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;
  // Observers for the long-hold instance.
  int  rep_rise = 0, rep_lo_run = 0, rep_last_gap = 0;
  logic rep_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      hi_run++;
      if (!prev_done) rise_cnt++;
    end else begin
      if (prev_done) last_hi_run = hi_run;
      hi_run = 0;
    end
    prev_done = (bus.done === 1'b1);

    if (bus.frame_err === 1'b1) begin
      err_run++;
      if (!prev_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end else begin
      if (prev_err) last_err_run = err_run;
      err_run = 0;
    end
    prev_err = (bus.frame_err === 1'b1);

    if (rbus.done === 1'b1) begin
      if (!rep_prev) begin
        rep_last_gap = rep_lo_run;
        rep_rise++;
      end
      rep_lo_run = 0;
    end else begin
      rep_lo_run++;
    end
    rep_prev = (rbus.done === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_tests++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Drive the low nbits of a frame, 40 system clocks per PS/2 bit.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (10) @(negedge clock);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (20) @(negedge clock);
      ps2_clk  = 1'b1;
      repeat (10) @(negedge clock);
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad_par);
    logic par;
    par = ~(^code) ^ bad_par;
    return {1'b1, par, code, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    int         exp_rise;
    logic [7:0] exp_tasta;
    logic       exp_ext;
    int         exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int r0, e0, q0, d;

    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;

    vecs[0] = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 0};
    vecs[1] = '{8'hF0, 1'b0, 0, 8'h1C, 1'b0, 0};
    vecs[2] = '{8'h1C, 1'b0, 0, 8'h1C, 1'b0, 0};
    vecs[3] = '{8'h23, 1'b0, 1, 8'h23, 1'b0, 0};
    vecs[4] = '{8'h29, 1'b1, 0, 8'h23, 1'b0, 1};
    vecs[5] = '{8'h29, 1'b0, 1, 8'h29, 1'b0, 0};
    vecs[6] = '{8'hE0, 1'b0, 0, 8'h29, 1'b0, 0};
    vecs[7] = '{8'h75, 1'b0, 1, 8'h75, 1'b1, 0};
    vecs[8] = '{8'h16, 1'b0, 1, 8'h16, 1'b0, 0};

    repeat (3) @(negedge clock);
    check("rst_tasta",     bus.tasta,     8'h00);
    check("rst_done",      bus.done,      1'b0);
    check("rst_extended",  bus.extended,  1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      r0 = rise_cnt;
      e0 = err_cnt;
      send_bits(make_frame(vecs[i].code, vecs[i].bad_par), 11);
      repeat (60) @(negedge clock);
      check($sformatf("v%0d_tasta", i),    bus.tasta,     vecs[i].exp_tasta);
      check($sformatf("v%0d_extended", i), bus.extended,  vecs[i].exp_ext);
      check($sformatf("v%0d_reports", i),  rise_cnt - r0, vecs[i].exp_rise);
      check($sformatf("v%0d_errors", i),   err_cnt - e0,  vecs[i].exp_err);
      if (vecs[i].exp_rise != 0) check($sformatf("v%0d_done_len", i), last_hi_run, 50);
      if (vecs[i].exp_err != 0)  check($sformatf("v%0d_err_len", i), last_err_run, 1);
    end

    // Frame abandoned after five bits: timeout error, then a clean frame.
    e0 = err_cnt;
    r0 = rise_cnt;
    send_bits(make_frame(8'h1E, 1'b0), 5);
    repeat (250) @(negedge clock);
    check("to_errors",  err_cnt - e0, 1);
    check("to_err_len", last_err_run, 1);
    check("to_reports", rise_cnt - r0, 0);
    d = err_cyc - fall_cyc;
    check_range("to_latency", d, 204, 206);
    e0 = err_cnt;
    r0 = rise_cnt;
    send_bits(make_frame(8'h1E, 1'b0), 11);
    repeat (20) @(negedge clock);
    check("after_to_tasta",   bus.tasta,     8'h1E);
    check("after_to_reports", rise_cnt - r0, 1);
    check("after_to_errors",  err_cnt - e0,  0);

    // Typematic repeats: long-hold instance must drop done for one clock.
    for (int k = 0; k < 3; k++) begin
      r0 = rise_cnt;
      q0 = rep_rise;
      send_bits(make_frame(8'h4B, 1'b0), 11);
      repeat (20) @(negedge clock);
      check($sformatf("rep%0d_tasta", k),     bus.tasta,     8'h4B);
      check($sformatf("rep%0d_reports", k),   rise_cnt - r0, 1);
      check($sformatf("rep%0d_long_tasta", k), rbus.tasta,   8'h4B);
      check($sformatf("rep%0d_long_rise", k), rep_rise - q0, 1);
      if (k > 0) check($sformatf("rep%0d_gap", k), rep_last_gap, 1);
    end

    // Reset in the middle of a frame, then a fresh frame.
    send_bits(make_frame(8'h4B, 1'b0), 4);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst_tasta",     bus.tasta,     8'h00);
    check("mid_rst_done",      bus.done,      1'b0);
    check("mid_rst_extended",  bus.extended,  1'b0);
    check("mid_rst_frame_err", bus.frame_err, 1'b0);
    check("mid_rst_long_done", rbus.done,     1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    r0 = rise_cnt;
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0), 11);
    repeat (20) @(negedge clock);
    check("post_rst_tasta",    bus.tasta,     8'h1C);
    check("post_rst_done",     bus.done,      1'b1);
    check("post_rst_extended", bus.extended,  1'b0);
    check("post_rst_reports",  rise_cnt - r0, 1);
    check("post_rst_errors",   err_cnt - e0,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
